bus_sequencer: RTL
==================

Name: bus_sequencer

Overview:
- Hardwired control unit for the 8-bit single-bus datapath.
- Each cycle it picks which of the eight sources drives the shared bus, and issues register-load, memory and ALU strobes.
- It steps a fetch/decode/execute state machine, with a ready handshake on the memory port.
- It sits beside the bus multiplexer and the register file, and takes IR contents and a DR-zero flag back from the datapath.

Parameters:
- OPC_W, 3, opcode field width (IR[7:5]).
- ADR_W, 5, direct address field width (IR[4:0]).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching at the current PC.
- ir  in  8  current IR contents.
- dr_zero  in  1  DR == 0 after increment (datapath flag).
- mem_ready  in  1  memory completes the pending access this cycle.
- bus_sel  out  3  bus source: 0 X, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEMORY.
- ld_ar  out  1  AR <= bus.
- ld_ar_adr  out  1  AR <= zero-extended bus[4:0].
- ld_pc  out  1  PC <= bus.
- inc_pc  out  1  PC <= PC+1.
- ld_ir  out  1  IR <= bus.
- ld_dr  out  1  DR <= bus.
- inc_dr  out  1  DR <= DR+1.
- ld_ac  out  1  AC <= ALU(AC, bus).
- alu_op  out  2  0 AND, 1 ADD, 2 PASS (bus to AC).
- mem_req  out  1  memory access pending.
- mem_we  out  1  with mem_req: write bus to M[AR].
- halted  out  1  HLT executed.

Behaviour:
- Reset: state IDLE; bus_sel=0; every strobe, mem_req, mem_we, alu_op and halted are 0. Reset mid-access drops mem_req the following cycle, with no handshake completion.
- Outputs are decoded combinationally from the registered state. The strobes that complete a memory access (ld_ir, ld_dr, inc_pc in FETCH1/ISZ write) are additionally gated by mem_ready.
- In states with no bus transfer, bus_sel=0.
- IDLE: all outputs 0. Go to FETCH0 when start=1.
- FETCH0: bus_sel=2, ld_ar. Go to FETCH1.
- FETCH1: bus_sel=7, mem_req. When mem_ready=1: ld_ir, inc_pc, go to DECODE; else stay (wait states unbounded).
- DECODE: bus_sel=5, ld_ar_adr. Dispatch on ir[7:5]:
  - 000 AND, 001 ADD, 010 LDA, 101 ISZ go to MEMRD.
  - 011 STA goes to WRITE.
  - 100 BUN goes to JUMP.
  - 111 HLT goes to HALT.
  - 110 is a NOP and goes to FETCH0.
- MEMRD: bus_sel=7, mem_req. On mem_ready: ld_dr, then EXEC (AND/ADD/LDA) or INCDR (ISZ).
- EXEC: bus_sel=3, ld_ac, alu_op = 0/1/2 for AND/ADD/LDA. Go to FETCH0.
- INCDR: inc_dr. Go to WRITE.
- WRITE:
  - bus_sel = 4 for STA, 3 for ISZ; mem_req and mem_we held until mem_ready.
  - On mem_ready: for ISZ, inc_pc if dr_zero=1; go to FETCH0.
  - bus_sel and mem_we stay stable while waiting.
- JUMP: bus_sel=1, ld_pc. Go to FETCH0.
- HALT: halted=1, all other outputs 0. Only rst leaves; start is ignored.
- Opcode latch:
  - The dispatched opcode is latched in DECODE into an internal register, because IR must not be trusted after DECODE.
  - EXEC and WRITE select off the latched opcode.
- Latency with mem_ready tied high:
  - LDA/ADD/AND: 5 cycles.
  - STA: 4 cycles.
  - BUN: 4 cycles.
  - ISZ: 6 cycles.
  - NOP: 3 cycles.
  - HLT: 3 cycles, then parks in HALT.
- Never assert ld_ar and ld_ar_adr together; never assert ld_pc and inc_pc together; at most one of ld_ir/ld_dr/ld_ac per cycle.
- mem_ready while mem_req=0 is ignored.
- start while not in IDLE is ignored.

Decomposition:
- Shared package holds:
  - bus source codes (X..MEMORY, 0..7), matching the bus multiplexer select encoding;
  - opcode constants;
  - alu_op codes;
  - the state enumeration.
- One sub-module, bus_seq_decode: a purely combinational state/opcode/mem_ready to control-vector decoder. The top keeps the state register, the opcode latch and the next-state logic.

Test Plan:
- rst held 2 cycles mid-FETCH1 (mem_req=1) -> cycle after release: IDLE, bus_sel=0, all strobes 0, mem_req=0.
- start, ir=8'h4A (LDA 0x0A), mem_ready=1 -> cycles 0..4:
  - bus_sel sequence 2, 7, 5, 7, 3;
  - ld_ar, ld_ir+inc_pc, ld_ar_adr, ld_dr, ld_ac with alu_op=2;
  - back in FETCH0 on cycle 5.
- ir=8'h65 (STA 0x05), mem_ready low 3 cycles in WRITE -> mem_req=mem_we=1 and bus_sel=4 held 4 cycles; no strobe until the ready cycle; then FETCH0.
- ir=8'hA3 (ISZ): run once with dr_zero=1 -> inc_pc=1 in the WRITE ready cycle; run again with dr_zero=0 -> inc_pc=0 there; inc_dr=1 exactly once per run.
- ir=8'h90 (BUN) -> JUMP: bus_sel=1, ld_pc=1, inc_pc=0; ir=8'hE0 (HLT) -> halted=1 persists for 10 cycles with start pulsed; cleared only by rst.
- ir=8'hC0 (NOP) -> FETCH0 three cycles after fetch start; a mem_ready pulse while in DECODE/EXEC causes no strobe.

Source files
------------

// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer_pkg: shared bus codes, opcodes, ALU codes, states and control vector
package bus_sequencer_pkg;
    localparam logic [2:0] BUS_X   = 3'd0;
    localparam logic [2:0] BUS_AR  = 3'd1;
    localparam logic [2:0] BUS_PC  = 3'd2;
    localparam logic [2:0] BUS_DR  = 3'd3;
    localparam logic [2:0] BUS_AC  = 3'd4;
    localparam logic [2:0] BUS_IR  = 3'd5;
    localparam logic [2:0] BUS_TR  = 3'd6;
    localparam logic [2:0] BUS_MEM = 3'd7;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_ISZ = 3'd5;
    localparam logic [2:0] OP_NOP = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;
    localparam logic [1:0] ALU_AND  = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_PASS = 2'd2;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_DECODE, S_MEMRD,
        S_EXEC, S_INCDR, S_WRITE, S_JUMP, S_HALT
    } state_t;
    typedef struct packed {
        logic [2:0] bus_sel;
        logic       ld_ar;
        logic       ld_ar_adr;
        logic       ld_pc;
        logic       inc_pc;
        logic       ld_ir;
        logic       ld_dr;
        logic       inc_dr;
        logic       ld_ac;
        logic [1:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic       halted;
    } ctrl_t;
    function automatic state_t dispatch(input logic [2:0] op);
        case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: return S_MEMRD;
            OP_STA:                         return S_WRITE;
            OP_BUN:                         return S_JUMP;
            OP_HLT:                         return S_HALT;
            default:                        return S_FETCH0;
        endcase
    endfunction
endpackage

// File: rtl/bus_seq_decode.sv
// bus_seq_decode: combinational state/opcode/mem_ready to control-vector decoder
module bus_seq_decode
    import bus_sequencer_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] op,
    input  logic       mem_ready,
    input  logic       dr_zero,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        ctrl.bus_sel = BUS_X;
        case (state)
            S_FETCH0: begin
                ctrl.bus_sel = BUS_PC;
                ctrl.ld_ar   = 1'b1;
            end
            S_FETCH1: begin
                ctrl.bus_sel = BUS_MEM;
                ctrl.mem_req = 1'b1;
                ctrl.ld_ir   = mem_ready;
                ctrl.inc_pc  = mem_ready;
            end
            S_DECODE: begin
                ctrl.bus_sel   = BUS_IR;
                ctrl.ld_ar_adr = 1'b1;
            end
            S_MEMRD: begin
                ctrl.bus_sel = BUS_MEM;
                ctrl.mem_req = 1'b1;
                ctrl.ld_dr   = mem_ready;
            end
            S_EXEC: begin
                ctrl.bus_sel = BUS_DR;
                ctrl.ld_ac   = 1'b1;
                ctrl.alu_op  = op == OP_AND ? ALU_AND : op == OP_ADD ? ALU_ADD : ALU_PASS;
            end
            S_INCDR: ctrl.inc_dr = 1'b1;
            S_WRITE: begin
                ctrl.bus_sel = op == OP_STA ? BUS_AC : BUS_DR;
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.inc_pc  = mem_ready && op == OP_ISZ && dr_zero;
            end
            S_JUMP: begin
                ctrl.bus_sel = BUS_AR;
                ctrl.ld_pc   = 1'b1;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: hardwired fetch/decode/execute controller for the 8-bit single-bus datapath
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int OPC_W = 3,
    parameter int ADR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [OPC_W+ADR_W-1:0] ir,
    input  logic                   dr_zero,
    input  logic                   mem_ready,
    output logic [2:0]             bus_sel,
    output logic                   ld_ar,
    output logic                   ld_ar_adr,
    output logic                   ld_pc,
    output logic                   inc_pc,
    output logic                   ld_ir,
    output logic                   ld_dr,
    output logic                   inc_dr,
    output logic                   ld_ac,
    output logic [1:0]             alu_op,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   halted
);
    state_t state, state_nxt;
    logic [OPC_W-1:0] op_q;
    logic [OPC_W-1:0] ir_op;
    logic unused_adr;
    ctrl_t ctrl;
    assign ir_op      = ir[OPC_W+ADR_W-1 -: OPC_W];
    assign unused_adr = ^ir[ADR_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= ir_op;
        end
    end
    // IR is only trusted in DECODE; later states look at op_q
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = start ? S_FETCH0 : S_IDLE;
            S_FETCH0: state_nxt = S_FETCH1;
            S_FETCH1: state_nxt = mem_ready ? S_DECODE : S_FETCH1;
            S_DECODE: state_nxt = dispatch(ir_op);
            S_MEMRD:  state_nxt = !mem_ready ? S_MEMRD : op_q == OP_ISZ ? S_INCDR : S_EXEC;
            S_EXEC:   state_nxt = S_FETCH0;
            S_INCDR:  state_nxt = S_WRITE;
            S_WRITE:  state_nxt = mem_ready ? S_FETCH0 : S_WRITE;
            S_JUMP:   state_nxt = S_FETCH0;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end
    bus_seq_decode u_decode (
        .state     (state),
        .op        (op_q),
        .mem_ready (mem_ready),
        .dr_zero   (dr_zero),
        .ctrl      (ctrl)
    );
    assign {bus_sel, ld_ar, ld_ar_adr, ld_pc, inc_pc, ld_ir, ld_dr, inc_dr, ld_ac,
            alu_op, mem_req, mem_we, halted} = ctrl;
endmodule
